// File: rtl/twiddle_mul1.sv
// twiddle_mul1: W64 twiddle rotator between SDF stage-1 and stage-2, 3-cycle latency.
// Define TW_SAT_EN to saturate the rotated result; otherwise it wraps to WIDTH bits.
module twiddle_mul1 #(
  parameter int WIDTH    = 17,
  parameter int TW_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             frame_start,
  input  logic [WIDTH-1:0] data_in_re,
  input  logic [WIDTH-1:0] data_in_im,
  output logic             out_valid,
  output logic             out_sof,
  output logic [WIDTH-1:0] data_out_re,
  output logic [WIDTH-1:0] data_out_im
);
  localparam int PW = WIDTH + TW_WIDTH;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] HALF = SW'(16384);
`ifdef TW_SAT_EN
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (WIDTH-1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  function automatic logic [WIDTH-1:0] sat(input logic signed [SW-1:0] x);
    return x > MAXV ? MAXV[WIDTH-1:0] : x < MINV ? MINV[WIDTH-1:0] : x[WIDTH-1:0];
  endfunction
`endif
  logic [5:0] idx_q, idx_d, cur;
  logic rot;
  logic signed [TW_WIDTH-1:0] tc, td;
  logic signed [WIDTH-1:0] a_q, b_q, a2_q, b2_q;
  logic signed [TW_WIDTH-1:0] c_q, d_q;
  logic rot1_q, v1_q, s1_q, rot2_q, v2_q, s2_q;
  logic signed [PW-1:0] ac_q, bd_q, ad_q, bc_q;
  logic signed [SW-1:0] re_s, im_s;
  logic [WIDTH-1:0] re_o, im_o, ore_q, oim_q;
  logic ov_q, os_q;
  // sample index: frame_start forces index 0, otherwise count valid samples
  always_comb begin
    cur = frame_start ? 6'd0 : idx_q;
    idx_d = in_valid ? cur + 6'd1 : idx_q;
    rot = cur[5] && (cur[4:0] != 5'd0);
  end
  // W64^n coefficients in Q1.15: c = cos, d = -sin
  always_comb begin
    case (cur[4:0])
      5'd1:    {tc, td} = {16'sd32609, -16'sd3212};
      5'd2:    {tc, td} = {16'sd32137, -16'sd6393};
      5'd3:    {tc, td} = {16'sd31356, -16'sd9512};
      5'd4:    {tc, td} = {16'sd30273, -16'sd12540};
      5'd5:    {tc, td} = {16'sd28898, -16'sd15447};
      5'd6:    {tc, td} = {16'sd27245, -16'sd18205};
      5'd7:    {tc, td} = {16'sd25329, -16'sd20788};
      5'd8:    {tc, td} = {16'sd23170, -16'sd23170};
      5'd9:    {tc, td} = {16'sd20787, -16'sd25330};
      5'd10:   {tc, td} = {16'sd18204, -16'sd27246};
      5'd11:   {tc, td} = {16'sd15446, -16'sd28899};
      5'd12:   {tc, td} = {16'sd12539, -16'sd30274};
      5'd13:   {tc, td} = {16'sd9512,  -16'sd31357};
      5'd14:   {tc, td} = {16'sd6393,  -16'sd32138};
      5'd15:   {tc, td} = {16'sd3212,  -16'sd32610};
      5'd16:   {tc, td} = {16'sd0,     16'sh8000};
      5'd17:   {tc, td} = {-16'sd3212,  -16'sd32610};
      5'd18:   {tc, td} = {-16'sd6393,  -16'sd32138};
      5'd19:   {tc, td} = {-16'sd9512,  -16'sd31357};
      5'd20:   {tc, td} = {-16'sd12539, -16'sd30274};
      5'd21:   {tc, td} = {-16'sd15446, -16'sd28899};
      5'd22:   {tc, td} = {-16'sd18204, -16'sd27246};
      5'd23:   {tc, td} = {-16'sd20787, -16'sd25330};
      5'd24:   {tc, td} = {-16'sd23170, -16'sd23170};
      5'd25:   {tc, td} = {-16'sd25329, -16'sd20788};
      5'd26:   {tc, td} = {-16'sd27245, -16'sd18205};
      5'd27:   {tc, td} = {-16'sd28898, -16'sd15447};
      5'd28:   {tc, td} = {-16'sd30273, -16'sd12540};
      5'd29:   {tc, td} = {-16'sd31356, -16'sd9512};
      5'd30:   {tc, td} = {-16'sd32137, -16'sd6393};
      5'd31:   {tc, td} = {-16'sd32609, -16'sd3212};
      default: {tc, td} = {16'sd32767, 16'sd0};
    endcase
  end
  // S3 combine: complex sum, round half up, then saturate or wrap
  always_comb begin
    re_s = ac_q - bd_q;
    im_s = ad_q + bc_q;
`ifdef TW_SAT_EN
    re_o = sat((re_s + HALF) >>> 15);
    im_o = sat((im_s + HALF) >>> 15);
`else
    re_o = WIDTH'((re_s + HALF) >>> 15);
    im_o = WIDTH'((im_s + HALF) >>> 15);
`endif
  end
  // index counter and the three pipeline stages, bypass path delay-matched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      {a_q, b_q, c_q, d_q, rot1_q, v1_q, s1_q} <= '0;
      {ac_q, bd_q, ad_q, bc_q, a2_q, b2_q, rot2_q, v2_q, s2_q} <= '0;
      {ore_q, oim_q, ov_q, os_q} <= '0;
    end else begin
      idx_q <= idx_d;
      a_q <= data_in_re;
      b_q <= data_in_im;
      c_q <= tc;
      d_q <= td;
      rot1_q <= rot;
      v1_q <= in_valid;
      s1_q <= in_valid && frame_start;
      ac_q <= a_q * c_q;
      bd_q <= b_q * d_q;
      ad_q <= a_q * d_q;
      bc_q <= b_q * c_q;
      a2_q <= a_q;
      b2_q <= b_q;
      rot2_q <= rot1_q;
      v2_q <= v1_q;
      s2_q <= s1_q;
      ore_q <= rot2_q ? re_o : a2_q;
      oim_q <= rot2_q ? im_o : b2_q;
      ov_q <= v2_q;
      os_q <= s2_q;
    end
  end
  assign data_out_re = ore_q;
  assign data_out_im = oim_q;
  assign out_valid = ov_q;
  assign out_sof = os_q;
endmodule

// File: tb/tb_twiddle_mul1.sv
// tb_twiddle_mul1: directed + random stimulus against a real-arithmetic W64 rotation model.
module tb_twiddle_mul1;
  localparam int W = 17;
  logic clk = 0, rst_n = 1, in_valid = 0, frame_start = 0;
  logic [W-1:0] data_in_re = '0, data_in_im = '0;
  logic out_valid, out_sof;
  logic [W-1:0] data_out_re, data_out_im;
  int checks = 0, errors = 0;
  int hv[2048], hs[2048], hre[2048], him[2048], hk[2048], hcr[2048], hci[2048];
  int step = 3, midx = 0, nout = 0, nsof = 0;
`ifdef TW_SAT_EN
  localparam int BIG_RE = 65535;
`else
  localparam int BIG_RE = -38393;
`endif

  twiddle_mul1 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame_start(frame_start),
    .data_in_re(data_in_re), .data_in_im(data_in_im),
    .out_valid(out_valid), .out_sof(out_sof),
    .data_out_re(data_out_re), .data_out_im(data_out_im)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int quant(input real x);
    int v;
    v = $rtoi(x);
`ifdef TW_SAT_EN
    return v > 65535 ? 65535 : v < -65536 ? -65536 : v;
`else
    v = ((v % 131072) + 131072) % 131072;
    return v >= 65536 ? v - 131072 : v;
`endif
  endfunction

  function automatic void model(input int a, input int b, input int n, output int re, output int im);
    real ang, c, d;
    if (n < 33) begin
      re = a;
      im = b;
      return;
    end
    ang = 2.0 * 3.14159265358979 * (n - 32) / 64.0;
    c = $floor(32767.0 * $cos(ang) + 0.5);
    d = $floor(-32768.0 * $sin(ang) + 0.5);
    if (d > 32767.0) d = 32767.0;
    re = quant($floor((a * c - b * d) / 32768.0 + 0.5));
    im = quant($floor((a * d + b * c) / 32768.0 + 0.5));
  endfunction

  function automatic int rnd();
    case ($urandom_range(0, 7))
      0: return -65536;
      1: return 65535;
      default: return int'($urandom_range(0, 131071)) - 65536;
    endcase
  endfunction

  // one clock: check the output owed from three samples ago, then drive the next sample
  task automatic tick(input bit v, input bit fs, input int re, input int im,
                      input bit ck, input int cr, input int ci);
    int j, n, er, ei;
    @(negedge clk);
    j = step - 3;
    chk("out_valid", int'(out_valid), hv[j]);
    chk("out_sof", int'(out_sof), hs[j]);
    nout += int'(out_valid);
    nsof += int'(out_sof);
    if (hv[j] != 0) begin
      chk("model_re", $signed(data_out_re), hre[j]);
      chk("model_im", $signed(data_out_im), him[j]);
      if (hk[j] != 0) begin
        chk("const_re", $signed(data_out_re), hcr[j]);
        chk("const_im", $signed(data_out_im), hci[j]);
      end
    end
    in_valid = v;
    frame_start = fs;
    data_in_re = re[W-1:0];
    data_in_im = im[W-1:0];
    er = 0;
    ei = 0;
    if (v) begin
      n = fs ? 0 : midx;
      model(re, im, n, er, ei);
      midx = (n + 1) % 64;
    end
    hv[step] = int'(v);
    hs[step] = int'(v && fs);
    hre[step] = er;
    him[step] = ei;
    hk[step] = int'(v && ck);
    hcr[step] = cr;
    hci[step] = ci;
    step++;
  endtask

  task automatic send(input bit fs);
    tick(1, fs, rnd(), rnd(), 0, 0, 0);
  endtask

  task automatic idle();
    tick(0, 0, rnd(), rnd(), 0, 0, 0);
  endtask

  // async reset for two cycles; everything in flight is discarded
  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 0;
    in_valid = 0;
    frame_start = 0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sof", int'(out_sof), 0);
    chk("rst_re", int'(data_out_re), 0);
    chk("rst_im", int'(data_out_im), 0);
    for (int k = 1; k <= 3; k++) begin
      hv[step-k] = 0;
      hs[step-k] = 0;
    end
    midx = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) rst_n = 1;
      hv[step] = 0;
      hs[step] = 0;
      step++;
    end
  endtask

  initial begin
    int g0, g1, g2, nv0, ns0;
    #2 rst_n = 0;
    #1;
    chk("init_valid", int'(out_valid), 0);
    chk("init_sof", int'(out_sof), 0);
    chk("init_re", int'(data_out_re), 0);
    chk("init_im", int'(data_out_im), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    send(1);
    for (int i = 1; i < 5; i++) send(0);
    tick(1, 0, 1234, -321, 1, 1234, -321);
    for (int i = 6; i < 40; i++) begin
      if (i == 17 || i == 29) idle();
      send(0);
    end
    tick(1, 0, 1000, 0, 1, 707, -707);
    for (int i = 41; i < 48; i++) send(0);
    tick(1, 0, 1000, 500, 1, 500, -1000);
    for (int i = 49; i < 64; i++) send(0);
    send(1);
    for (int i = 1; i < 40; i++) send(0);
    tick(1, 0, 65535, 65535, 1, BIG_RE, 0);
    for (int i = 41; i < 45; i++) send(0);
    reset_pulse();
    tick(1, 0, 777, -555, 1, 777, -555);
    for (int i = 0; i < 6; i++) send(0);
    repeat (4) idle();
    nv0 = nout;
    ns0 = nsof;
    g0 = $urandom_range(1, 20);
    g1 = $urandom_range(21, 40);
    g2 = $urandom_range(41, 63);
    for (int i = 0; i < 64; i++) begin
      if (i == g0 || i == g1 || i == g2) idle();
      send(i == 0);
    end
    repeat (4) idle();
    chk("frame_valids", nout - nv0, 64);
    chk("frame_sofs", nsof - ns0, 1);
    send(1);
    for (int i = 1; i < 20; i++) send(0);
    send(1);
    for (int i = 1; i < 45; i++) send(0);
    repeat (400) tick($urandom_range(0, 9) != 0, $urandom_range(0, 40) == 0, rnd(), rnd(), 0, 0, 0);
    repeat (4) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/twiddle_mul1.md
Name: twiddle_mul1

Overview:
- Twiddle-factor rotator placed directly after the first radix-2 SDF processing element in the 64-point pipeline FFT, and before the second processing element.
- Consumes the stage-1 output stream, one complex sample per cycle.
- Samples 0..31 of each frame (butterfly sums) pass through unrotated.
- Samples 32..63 (butterfly differences) are multiplied by W64^n = exp(-j·2πn/64), n = index-32.
- Output is rounded and saturated back to WIDTH bits, then forwarded to the next stage.

Parameters:
- WIDTH, 17, signed two's-complement width of the data re/im inputs and outputs.
- TW_WIDTH, 16, signed Q1.15 twiddle coefficient width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  data_in_re/im carry a valid sample this cycle.
- frame_start  in  1  marks the current valid sample as frame index 0; ignored when in_valid=0.
- data_in_re  in  WIDTH  real part from stage-1 PE.
- data_in_im  in  WIDTH  imaginary part from stage-1 PE.
- out_valid  out  1  data_out_re/im valid.
- out_sof  out  1  output sample is frame index 0.
- data_out_re  out  WIDTH  rotated real part.
- data_out_im  out  WIDTH  rotated imaginary part.

Behaviour:
- Reset (async assert, sync release): idx=0, all pipeline registers 0; out_valid, out_sof, data_out_re and data_out_im all 0.
- Index counter idx[5:0]:
  - On in_valid with frame_start=1: current sample uses index 0, then idx<=1.
  - On in_valid with frame_start=0: current sample uses idx, then idx<=idx+1, wrapping 63->0.
  - With in_valid=0: idx holds.
  - A frame_start arriving mid-frame resynchronises immediately; no error flag.
- Twiddle ROM:
  - 32 entries, combinational case table, addressed by idx[4:0].
  - Entry n: c = round(32767·cos(2πn/64)), d = round(-32768·sin(2πn/64)) clipped to [-32768, 32767].
  - Required entries: n=8 gives c=23170, d=-23170; n=16 gives c=0, d=-32768.
- Bypass: rot = idx[5]&&(idx[4:0]!=0). When rot=0 (idx 0..31, or idx 32) the sample passes unmodified through a delay-matched path; no rounding.
- Pipeline, fixed latency 3 cycles, advancing every clock regardless of in_valid:
  - S1: register a, b (input re/im), c, d, rot, valid, sof.
  - S2: register the four products a·c, b·d, a·d, b·c, each WIDTH+TW_WIDTH bits signed.
  - S3:
    - re = a·c - b·d and im = a·d + b·c, computed at WIDTH+TW_WIDTH+1 bits.
    - Add 2^14, arithmetic shift right 15 (round half up).
    - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
    - Select the bypass value if rot=0.
    - Register the result into data_out.
- out_valid and out_sof equal in_valid and (in_valid&frame_start) delayed 3 cycles.
- data_out changes every cycle; it is meaningful only when out_valid=1.
- Gaps: bubbles in in_valid propagate as out_valid=0 bubbles; sample order and index are preserved.
- Reset mid-frame clears everything in flight. The next frame requires a frame_start; without one, the index restarts at 0 with the next valid sample.

Optional Feature:
- TW_SAT_EN defined (default build): S3 saturates as described.
- TW_SAT_EN undefined: S3 truncates to the low WIDTH bits after the shift (two's-complement wrap), with no saturation logic.

Test Plan:
- Index 5, input (1234,-321) -> output (1234,-321) exactly, out_valid 3 cycles after in_valid.
- Index 40 (n=8), input (1000,0) -> output (707,-707).
- Index 48 (n=16), input (1000,500) -> output (500,-1000).
- Index 40, input (65535,65535):
  - with TW_SAT_EN -> output (65535,0);
  - without TW_SAT_EN -> output (-38393,0).
- Full 64-sample frame with frame_start on the first sample and 3 random in_valid gaps -> out_sof on the first output only, 64 out_valid pulses, order preserved; the second frame's frame_start restarts at index 0.
- Assert rst_n=0 at index 45 for 2 cycles -> outputs/out_valid 0 within same cycle; next sample without frame_start treated as index 0 (bypassed).
